epcs_flash_responder: RTL



---
 rtl/epcs_flash_responder.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/epcs_flash_responder.sv
// epcs_flash_responder: SPI-slave model of an EPCS configuration flash.
// The master pins are synchronised into clk_clk, and the command FSM runs on
// detected DCLK edges. The memory is a byte array with a preload port.
// Optional: define EPCS_RESP_PROGRAM_EN to enable 0x02 PAGE PROGRAM.
module epcs_flash_responder #(
  parameter int          MEM_BYTES   = 4096,
  parameter logic [7:0]  SILICON_ID  = 8'h16,
  parameter int          PROG_CYCLES = 64
) (
  input  logic                         clk_clk,
  input  logic                         reset_n_reset_n,
  input  logic                         epcs_dclk,
  input  logic                         epcs_sce,
  input  logic                         epcs_sdo,
  output logic                         epcs_data0,
  input  logic                         load_we,
  input  logic [$clog2(MEM_BYTES)-1:0] load_addr,
  input  logic [7:0]                   load_data,
  output logic                         busy,
  output logic                         cmd_error
);
  localparam int AW     = $clog2(MEM_BYTES);
  localparam int PW     = $clog2(PROG_CYCLES + 1);
  localparam int STAGES = 1;

  typedef enum logic [2:0] {IDLE, OPCODE, ADDR, DUMMY, DATA_OUT, DATA_IN} state_t;
  typedef enum logic [1:0] {SRC_MEM, SRC_STAT, SRC_SID} src_t;

  logic [2:0]      dclk_sy, sce_sy;
  logic [1:0]      sdo_sy;
  logic            dclk_rise, dclk_fall, sce_s, sce_rise, sce_fall;
  state_t          state;
  src_t            src;
  logic [2:0]      bit_cnt;
  logic [1:0]      byte_cnt;
  logic [6:0]      shreg;
  logic [7:0]      rx_byte, out_sr, rd_data, status;
  logic [AW-1:0]   addr, pp_wa;
  logic [7:0]      pp_wd;
  logic            pp_we, pp_act, pp_got;
  logic            op_wren, op_wrdi, wel, wip;
  logic [PW-1:0]   prog_cnt;
  logic [STAGES:0] vld_pipe;
  logic [7:0]      mem [MEM_BYTES];

  assign dclk_rise = dclk_sy[1] & ~dclk_sy[2];
  assign dclk_fall = ~dclk_sy[1] & dclk_sy[2];
  assign sce_s     = sce_sy[1];
  assign sce_rise  = sce_sy[1] & ~sce_sy[2];
  assign sce_fall  = ~sce_sy[1] & sce_sy[2];
  assign rx_byte   = {shreg, sdo_sy[1]};
  assign status    = {6'b0, wel, wip};
  assign busy      = wip;

  // Two-flop synchronisers plus one history flop for edge detection.
  always_ff @(posedge clk_clk or negedge reset_n_reset_n) begin
    if (!reset_n_reset_n) begin
      dclk_sy <= '0;
      sce_sy  <= '1;
      sdo_sy  <= '0;
    end else begin
      dclk_sy <= {dclk_sy[1:0], epcs_dclk};
      sce_sy  <= {sce_sy[1:0], epcs_sce};
      sdo_sy  <= {sdo_sy[0], epcs_sdo};
    end
  end

  // Byte memory: preload and page-program writes (PP last, so it wins), registered read.
  always_ff @(posedge clk_clk) begin
    if (load_we) mem[load_addr] <= load_data;
    if (pp_we)   mem[pp_wa]     <= pp_wd;
    rd_data <= mem[addr];
  end

  // Command FSM, status register and serial output.
  // Outgoing bytes are loaded via vld_pipe so the registered memory read settles
  // before the next falling DCLK edge (at least 3 clk away at the 8x clock ratio).
  always_ff @(posedge clk_clk or negedge reset_n_reset_n) begin
    if (!reset_n_reset_n) begin
      state      <= IDLE;
      src        <= SRC_MEM;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      shreg      <= '0;
      addr       <= '0;
      out_sr     <= '0;
      vld_pipe   <= '0;
      epcs_data0 <= 1'b0;
      wel        <= 1'b0;
      wip        <= 1'b0;
      prog_cnt   <= '0;
      cmd_error  <= 1'b0;
      op_wren    <= 1'b0;
      op_wrdi    <= 1'b0;
      pp_act     <= 1'b0;
      pp_got     <= 1'b0;
      pp_we      <= 1'b0;
      pp_wa      <= '0;
      pp_wd      <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], 1'b0};
      pp_we    <= 1'b0;
      if (wip) begin
        if (prog_cnt == PW'(1)) begin
          wip <= 1'b0;
          wel <= 1'b0;
        end else begin
          prog_cnt <= prog_cnt - PW'(1);
        end
      end
      if (sce_s) begin
        state      <= IDLE;
        bit_cnt    <= '0;
        byte_cnt   <= '0;
        epcs_data0 <= 1'b0;
        if (sce_rise) begin
          if (op_wren) wel <= 1'b1;
          if (op_wrdi) wel <= 1'b0;
          if (pp_act) begin
            if (pp_got) begin
              wip      <= 1'b1;
              prog_cnt <= PW'(PROG_CYCLES);
            end else begin
              wel <= 1'b0;
            end
          end
          op_wren <= 1'b0;
          op_wrdi <= 1'b0;
          pp_act  <= 1'b0;
          pp_got  <= 1'b0;
        end
      end else if (sce_fall) begin
        state    <= OPCODE;
        bit_cnt  <= '0;
        byte_cnt <= '0;
      end else begin
        if (dclk_rise) begin
          shreg   <= rx_byte[6:0];
          bit_cnt <= bit_cnt + 3'd1;
          // WREN/WRDI only take effect if no bit follows the opcode
          op_wren <= 1'b0;
          op_wrdi <= 1'b0;
          if (bit_cnt == 3'd7) begin
            case (state)
              OPCODE: begin
                byte_cnt <= '0;
                if (wip && rx_byte != 8'h05) begin
                  state <= IDLE;
                end else begin
                  case (rx_byte)
                    8'h03: state <= ADDR;
                    8'h05: begin
                      state       <= DATA_OUT;
                      src         <= SRC_STAT;
                      vld_pipe[0] <= 1'b1;
                    end
                    8'h06: begin op_wren <= 1'b1; state <= IDLE; end
                    8'h04: begin op_wrdi <= 1'b1; state <= IDLE; end
                    8'hAB: state <= DUMMY;
`ifdef EPCS_RESP_PROGRAM_EN
                    8'h02: begin
                      if (wel) begin
                        state  <= ADDR;
                        pp_act <= 1'b1;
                      end else begin
                        state <= IDLE;
                      end
                    end
`endif
                    default: begin cmd_error <= 1'b1; state <= IDLE; end
                  endcase
                end
              end
              ADDR: begin
                addr     <= AW'({addr, rx_byte});
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_cnt == 2'd2) begin
                  if (pp_act) begin
                    state <= DATA_IN;
                  end else begin
                    state       <= DATA_OUT;
                    src         <= SRC_MEM;
                    vld_pipe[0] <= 1'b1;
                  end
                end
              end
              DUMMY: begin
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_cnt == 2'd2) begin
                  state       <= DATA_OUT;
                  src         <= SRC_SID;
                  vld_pipe[0] <= 1'b1;
                end
              end
              DATA_OUT: begin
                if (src == SRC_MEM) addr <= addr + AW'(1);
                vld_pipe[0] <= 1'b1;
              end
              DATA_IN: begin
                pp_we      <= 1'b1;
                pp_wa      <= addr;
                pp_wd      <= rx_byte;
                pp_got     <= 1'b1;
                addr[7:0]  <= addr[7:0] + 8'd1;
              end
              default: ;
            endcase
          end
        end
        if (dclk_fall) begin
          if (state == DATA_OUT) begin
            epcs_data0 <= out_sr[7];
            out_sr     <= {out_sr[6:0], 1'b0};
          end else begin
            epcs_data0 <= 1'b0;
          end
        end
      end
      if (vld_pipe[STAGES]) begin
        case (src)
          SRC_STAT: out_sr <= status;
          SRC_SID:  out_sr <= SILICON_ID;
          default:  out_sr <= rd_data;
        endcase
      end
    end
  end
endmodule
